// File: rtl/func_sweep_checker.sv
// ============================================================================
// func_sweep_checker : sweeps {A,B,C,D}=0..15 into a 4-input unit, checks F
// Rev 1.0
// ============================================================================
`default_nettype none

module func_sweep_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       start,
  input  logic       abort,
  input  logic       F,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [4:0] ones_count,
  output logic [3:0] first_err_vec,
  output logic       first_err_valid
);

  localparam logic [3:0] c_SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     state_q;
  logic [3:0] vec_q;
  logic [3:0] abcd_q;
  logic [3:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [4:0] err_q;
  logic [4:0] ones_q;
  logic [3:0] fev_q;
  logic       fevv_q;

  logic       w_golden;
  logic       w_sample;
  logic       w_mismatch;
  logic [4:0] err_d;
  logic [4:0] ones_d;

  // Reference copy of F = A'B'CD + A'B + ABD + A(B'CD' + C'D)
  always_comb begin
    w_golden = (~vec_q[3] & ~vec_q[2] &  vec_q[1] &  vec_q[0])
             | (~vec_q[3] &  vec_q[2])
             | ( vec_q[3] &  vec_q[2] &  vec_q[0])
             | ( vec_q[3] & ((~vec_q[2] & vec_q[1] & ~vec_q[0]) | (~vec_q[1] & vec_q[0])));
  end

  always_comb begin
    w_sample   = (state_q == S_SWEEP) && (cnt_q == c_SETTLE_CNT);
    w_mismatch = w_sample && (F != w_golden);
    err_d      = err_q  + {4'd0, w_mismatch};
    ones_d     = ones_q + {4'd0, w_sample & F};
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      vec_q   <= 4'd0;
      abcd_q  <= 4'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 5'd0;
      ones_q  <= 5'd0;
      fev_q   <= 4'd0;
      fevv_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_SWEEP;
            busy_q  <= 1'b1;
            vec_q   <= 4'd0;
            abcd_q  <= 4'd0;
            cnt_q   <= 4'd0;
            err_q   <= 5'd0;
            ones_q  <= 5'd0;
            fev_q   <= 4'd0;
            fevv_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        S_SWEEP: begin
          // A sample landing in the abort cycle is still accounted for
          err_q  <= err_d;
          ones_q <= ones_d;
          if (w_mismatch && !fevv_q) begin
            fevv_q <= 1'b1;
            fev_q  <= vec_q;
          end
          cnt_q <= w_sample ? 4'd0 : cnt_q + 4'd1;
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            abcd_q  <= 4'd0;
          end else if (w_sample) begin
            if (vec_q == 4'd15) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              abcd_q  <= 4'd0;
              pass_q  <= (err_d == 5'd0);
            end else begin
              vec_q  <= vec_q + 4'd1;
              abcd_q <= vec_q + 4'd1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          abcd_q  <= 4'd0;
        end
      endcase
    end
  end

  assign {A, B, C, D}    = abcd_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign ones_count      = ones_q;
  assign first_err_vec   = fev_q;
  assign first_err_valid = fevv_q;

endmodule

`default_nettype wire
